// File: rtl/sar_search_if.sv
// Comparator/control bus between the SAR search initiator and its environment.
// master = search engine side, slave = comparator/controller side.
interface sar_search_if #(
    parameter int WIDTH = 8,
    parameter int CW    = 4
) ();
    logic             start;
    logic             AEB;
    logic             ASB;
    logic             AGB;
    logic [WIDTH-1:0] guess;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] found;
    logic [CW-1:0]    probes;
    logic             err;

    modport master (
        input  start, AEB, ASB, AGB,
        output guess, busy, done, found, probes, err
    );

    modport slave (
        output start, AEB, ASB, AGB,
        input  guess, busy, done, found, probes, err
    );
endinterface

// File: rtl/sar_search.sv
// Binary-search initiator: probes an external magnitude comparator one guess
// per clock and reports the matched value, probe count and a consistency error.
module sar_search #(
    parameter int WIDTH = 8,
    parameter int CW    = 4
) (
    input  logic        clk,
    input  logic        rst,
    sar_search_if.master bus
);
    typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

    localparam logic [WIDTH:0]   MAXB = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH:0]   ONE  = (WIDTH+1)'(1);
    localparam logic [WIDTH-1:0] GMAX = {WIDTH{1'b1}};

    state_t           state_q, state_d;
    logic [WIDTH:0]   lo_q, lo_d, hi_q, hi_d;
    logic [WIDTH-1:0] guess_q, guess_d;
    logic [WIDTH-1:0] found_q, found_d;
    logic [CW-1:0]    probes_q, probes_d;
    logic             err_q, err_d;

    logic             onehot;
    logic [WIDTH:0]   lo_up, hi_dn;

    // Bounds are one bit wider than the guess, so the sum never overflows.
    function automatic logic [WIDTH-1:0] mid(input logic [WIDTH:0] l, input logic [WIDTH:0] h);
        return WIDTH'((l + h) >> 1);
    endfunction

    assign onehot = ({bus.AEB, bus.ASB, bus.AGB} == 3'b100) ||
                    ({bus.AEB, bus.ASB, bus.AGB} == 3'b010) ||
                    ({bus.AEB, bus.ASB, bus.AGB} == 3'b001);
    assign lo_up  = {1'b0, guess_q} + ONE;
    assign hi_dn  = {1'b0, guess_q} - ONE;

    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        guess_d  = guess_q;
        found_d  = found_q;
        probes_d = probes_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    lo_d     = '0;
                    hi_d     = MAXB;
                    guess_d  = mid('0, MAXB);
                    probes_d = '0;
                    err_d    = 1'b0;
                    state_d  = EVAL;
                end
            end
            EVAL: begin
                probes_d = probes_q + 1'b1;
                if (!onehot) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (bus.AEB) begin
                    found_d = guess_q;
                    state_d = DONE;
                end else if (bus.ASB) begin
                    // guess below B at the top of the range cannot be consistent
                    if (guess_q == GMAX) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        lo_d = lo_up;
                        if (lo_up > hi_q) begin
                            err_d   = 1'b1;
                            state_d = DONE;
                        end else begin
                            guess_d = mid(lo_up, hi_q);
                        end
                    end
                end else begin
                    if (guess_q == '0) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        hi_d = hi_dn;
                        if (lo_q > hi_dn) begin
                            err_d   = 1'b1;
                            state_d = DONE;
                        end else begin
                            guess_d = mid(lo_q, hi_dn);
                        end
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            lo_q     <= '0;
            hi_q     <= '0;
            guess_q  <= '0;
            found_q  <= '0;
            probes_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            guess_q  <= guess_d;
            found_q  <= found_d;
            probes_q <= probes_d;
            err_q    <= err_d;
        end
    end

    assign bus.guess  = guess_q;
    assign bus.busy   = (state_q == EVAL);
    assign bus.done   = (state_q == DONE);
    assign bus.found  = found_q;
    assign bus.probes = probes_q;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_sar_search.sv
// Bench for sar_search: comparator model driven from the guess, integer-level
// search reference producing a per-cycle expectation queue, checked each cycle.
module tb_sar_search;
    localparam int WIDTH = 8;
    localparam int CW    = 4;

    typedef struct {
        bit         done;
        logic [7:0] guess;
        logic [3:0] probes;
        logic [7:0] found;
        bit         err;
    } rec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   chk_en = 1'b0;

    logic [7:0] b_val = 8'h00;
    int         mode = 0;
    int         seed = 0;

    rec_t q[$];
    int   mq[$];
    bit   m_err;
    int   m_found;

    logic [7:0] exp_guess = 0, exp_found = 0;
    logic [3:0] exp_probes = 0;
    bit         exp_err = 0;

    logic [7:0] exp5a [8] = '{8'h7F, 8'h3F, 8'h5F, 8'h4F, 8'h57, 8'h5B, 8'h59, 8'h5A};

    sar_search_if #(.WIDTH(WIDTH), .CW(CW)) bus ();
    sar_search #(.WIDTH(WIDTH), .CW(CW)) dut (.clk(clk), .rst(rst), .bus(bus.master));

    always #5 clk = ~clk;

    // {AEB,ASB,AGB} response; modes 1..4 model faulty comparators
    function automatic logic [2:0] flags(input int g, input int b, input int m, input int s);
        int h;
        logic [2:0] good;
        good = (g == b) ? 3'b100 : (g < b) ? 3'b010 : 3'b001;
        case (m)
            1: return 3'b000;
            2: return 3'b010;
            4: return 3'b001;
            3: begin
                h = (g * 131 + s * 7 + (g >> 3)) & 32'h7fffffff;
                case (h % 6)
                    2: return 3'b000;
                    3: return 3'b011;
                    4: return 3'b010;
                    5: return 3'b001;
                    default: return good;
                endcase
            end
            default: return good;
        endcase
    endfunction

    always_comb {bus.AEB, bus.ASB, bus.AGB} = flags(int'(bus.guess), int'(b_val), mode, seed);

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain interval search over integers
    task automatic predict(input int b, input int m, input int s);
        int lo, hi, g;
        logic [2:0] f;
        mq.delete();
        m_err = 0;
        m_found = -1;
        lo = 0;
        hi = (1 << WIDTH) - 1;
        for (int n = 0; n < 20; n++) begin
            g = (lo + hi) / 2;
            mq.push_back(g);
            f = flags(g, b, m, s);
            if (!(f == 3'b100 || f == 3'b010 || f == 3'b001)) begin m_err = 1; break; end
            if (f[2]) begin m_found = g; break; end
            if (f[1]) begin
                if (g == (1 << WIDTH) - 1) begin m_err = 1; break; end
                lo = g + 1;
            end else begin
                if (g == 0) begin m_err = 1; break; end
                hi = g - 1;
            end
            if (lo > hi) begin m_err = 1; break; end
        end
    endtask

    always @(negedge clk) begin
        rec_t r;
        if (chk_en) begin
            if (q.size() != 0) begin
                r = q.pop_front();
                chk("busy", bus.busy, !r.done);
                chk("done", bus.done, r.done);
                chk("probes", bus.probes, r.probes);
                if (!r.done) chk("guess", bus.guess, r.guess);
                else begin
                    chk("err", bus.err, r.err);
                    if (!r.err) chk("found", bus.found, r.found);
                end
            end else begin
                chk("idle_busy", bus.busy, 0);
                chk("idle_done", bus.done, 0);
                chk("idle_guess", bus.guess, exp_guess);
                chk("idle_found", bus.found, exp_found);
                chk("idle_probes", bus.probes, exp_probes);
                chk("idle_err", bus.err, exp_err);
            end
        end
    end

    task automatic run_search(input logic [7:0] b, input int m, input bit ign);
        rec_t r;
        int len, k;
        @(negedge clk);
        b_val = b;
        mode = m;
        bus.start = 1'b1;
        predict(int'(b), m, seed);
        @(posedge clk);
        for (int i = 0; i < mq.size(); i++) begin
            r = '{done: 0, guess: 8'(mq[i]), probes: 4'(i), found: 8'h00, err: 0};
            q.push_back(r);
        end
        r = '{done: 1, guess: 8'(mq[$]), probes: 4'(mq.size()), found: 8'(m_found), err: m_err};
        q.push_back(r);
        exp_guess  = 8'(mq[$]);
        exp_probes = 4'(mq.size());
        exp_err    = m_err;
        if (!m_err) exp_found = 8'(m_found);
        #1 bus.start = 1'b0;
        len = mq.size() + 1;
        k = $urandom_range(1, len);
        for (int i = 1; i <= len; i++) begin
            bus.start = ign && (i == k);
            @(posedge clk);
            #1 bus.start = 1'b0;
        end
    endtask

    task automatic reset_mid(input logic [7:0] b);
        rec_t r;
        @(negedge clk);
        b_val = b;
        mode = 0;
        bus.start = 1'b1;
        predict(int'(b), 0, seed);
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            r = '{done: 0, guess: 8'(mq[i]), probes: 4'(i), found: 8'h00, err: 0};
            q.push_back(r);
        end
        #1 bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_guess = 0; exp_found = 0; exp_probes = 0; exp_err = 0;
    endtask

    initial begin
        int r;
        rst = 1'b1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_guess", bus.guess, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_found", bus.found, 0);
        chk("rst_probes", bus.probes, 0);
        chk("rst_err", bus.err, 0);
        rst = 1'b0;
        chk_en = 1'b1;

        // pin the reference model to hand-derived sequences
        predict(8'h5A, 0, 0);
        chk("model_5a_len", mq.size(), 8);
        for (int i = 0; i < 8; i++) chk("model_5a_seq", mq[i], exp5a[i]);
        predict(8'hFF, 0, 0);
        chk("model_ff_len", mq.size(), 9);
        predict(8'h00, 0, 0);
        chk("model_00_len", mq.size(), 8);

        run_search(8'h5A, 0, 0);
        chk("t1_found", bus.found, 8'h5A);
        chk("t1_probes", bus.probes, 8);
        chk("t1_err", bus.err, 0);
        run_search(8'h7F, 0, 0);
        chk("t2_found", bus.found, 8'h7F);
        chk("t2_probes", bus.probes, 1);
        run_search(8'hFF, 0, 0);
        chk("t3_found_ff", bus.found, 8'hFF);
        chk("t3_probes_ff", bus.probes, 9);
        chk("t3_guess_ff", bus.guess, 8'hFF);
        run_search(8'h00, 0, 0);
        chk("t3_found_00", bus.found, 8'h00);
        chk("t3_probes_00", bus.probes, 8);
        run_search(8'h40, 1, 0);
        chk("t4_err_none", bus.err, 1);
        chk("t4_probes_none", bus.probes, 1);
        chk("t4_found_held", bus.found, 8'h00);
        run_search(8'h40, 2, 0);
        chk("t4_err_top", bus.err, 1);
        chk("t4_guess_top", bus.guess, 8'hFF);
        reset_mid(8'h33);
        run_search(8'h33, 0, 0);
        chk("t5_found", bus.found, 8'h33);
        run_search(8'hA7, 0, 1);
        chk("t6_found_ign", bus.found, 8'hA7);
        run_search(8'h12, 0, 0);
        chk("t6_found_b2b", bus.found, 8'h12);

        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            seed = $urandom;
            run_search(8'($urandom), (r < 6) ? 0 : (r == 6) ? 3 : (r == 7) ? 1 : (r == 8) ? 2 : 4,
                       $urandom_range(0, 2) == 0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
